// File: rtl/loader_pkg.sv
// Shared state encoding and default slot base addresses for the SDRAM loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    HOLD
  } state_t;

  // Slot 1 in the upper half, slot 0 in the lower half.
  localparam logic [49:0] BASE_TABLE_DEFAULT = {25'h0A8000, 25'h080000};

endpackage

// File: rtl/sdram_loader_if.sv
// Download-side (data_io) and SDRAM-side signals of the loader, bundled as one port.
interface sdram_loader_if #(
  parameter int unsigned ADDR_W = 25
) ();

  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              mem_sync;

  logic              loader_active;
  logic              loader_we;
  logic [ADDR_W-1:0] loader_addr;
  logic [7:0]        loader_data;
  logic              reset_req;
  logic              overflow;
  logic              bad_index;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
    input  loader_active, loader_we, loader_addr, loader_data, reset_req, overflow, bad_index
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
    output loader_active, loader_we, loader_addr, loader_data, reset_req, overflow, bad_index
  );

endinterface

// File: rtl/loader_fifo.sv
// Synchronous write buffer; head entry is visible combinationally on rdata.
module loader_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sdram_loader.sv
// Buffers data_io download bytes and replays them into SDRAM, one write per mem_sync slot,
// then stretches the core reset for HOLD_CYCLES once the download has drained.
module sdram_loader
  import loader_pkg::*;
#(
  parameter int unsigned                ADDR_W      = 25,
  parameter int unsigned                DEPTH       = 4,
  parameter int unsigned                NUM_IDX     = 2,
  parameter logic [NUM_IDX*ADDR_W-1:0]  BASE_TABLE  = BASE_TABLE_DEFAULT,
  parameter int unsigned                HOLD_CYCLES = 4095
) (
  input  logic          clk_sys,
  input  logic          reset,
  sdram_loader_if.slave bus
);

  localparam int unsigned CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);

  state_t            state;
  logic [7:0]        idx;
  logic [CNT_W-1:0]  hold_cnt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] push_addr;
  logic              idx_ok;
  logic              take;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic [ADDR_W+7:0] head;

  always_comb begin
    base = '0;
    for (int unsigned i = 0; i < NUM_IDX; i++) begin
      if ({24'd0, idx} == i) base = BASE_TABLE[i*ADDR_W +: ADDR_W];
    end
  end

  assign idx_ok    = ({24'd0, idx} < NUM_IDX);
  assign push_addr = base + bus.ioctl_addr;
  assign take      = (state == LOAD) && bus.ioctl_wr && idx_ok;
  // Byte arriving on a slot with an empty buffer goes straight to the SDRAM registers.
  assign bypass    = take && empty && bus.mem_sync;
  assign fifo_pop  = bus.mem_sync && !empty;
  assign fifo_push = take && !bypass && (!full || fifo_pop);
  assign drop      = take && full && !bus.mem_sync;

  loader_fifo #(
    .WIDTH (ADDR_W + 8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({push_addr, bus.ioctl_dout}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      hold_cnt          <= '0;
      bus.loader_active <= 1'b0;
      bus.loader_we     <= 1'b0;
      bus.loader_addr   <= '0;
      bus.loader_data   <= '0;
      bus.reset_req     <= 1'b0;
      bus.overflow      <= 1'b0;
      bus.bad_index     <= 1'b0;
    end else begin
      if (bus.mem_sync) begin
        bus.loader_we <= fifo_pop || bypass;
        if (fifo_pop) begin
          {bus.loader_addr, bus.loader_data} <= head;
        end else if (bypass) begin
          bus.loader_addr <= push_addr;
          bus.loader_data <= bus.ioctl_dout;
        end
      end

      if (drop) bus.overflow <= 1'b1;
      if ((state == LOAD) && !idx_ok) bus.bad_index <= 1'b1;

      case (state)
        IDLE, HOLD: begin
          if (bus.ioctl_download) begin
            state             <= LOAD;
            idx               <= bus.ioctl_index;
            hold_cnt          <= '0;
            bus.overflow      <= 1'b0;
            bus.bad_index     <= 1'b0;
            bus.loader_active <= 1'b1;
            bus.reset_req     <= 1'b1;
          end else if (state == HOLD) begin
            if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              state         <= IDLE;
              hold_cnt      <= '0;
              bus.reset_req <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        LOAD: begin
          if (!bus.ioctl_download) state <= DRAIN;
        end
        DRAIN: begin
          if (bus.mem_sync && empty) begin
            state             <= HOLD;
            hold_cnt          <= '0;
            bus.loader_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_loader.sv
// Bench for sdram_loader: table of single-byte downloads, hand sequences for buffering,
// overflow, reset stretch and async reset, plus random traffic against a queue model.
module tb_sdram_loader;

  localparam int unsigned AW    = 25;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 4095;
  localparam logic [49:0] BASES = {25'h0A8000, 25'h080000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_loader_if #(.ADDR_W(AW)) bus ();

  sdram_loader #(
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .NUM_IDX     (2),
    .BASE_TABLE  (BASES),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queue of {addr,data}, phase as a plain int)
  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_t;

  int          m_phase = 0;   // 0 idle, 1 load, 2 drain, 3 hold
  int          m_left  = 0;
  logic [7:0]  m_slot  = '0;
  wr_t         m_q[$];
  logic        m_we = 0, m_ovf = 0, m_bad = 0;
  logic [24:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic        prev_sync = 0;
  wr_t         writes[$];

  function automatic logic [24:0] base_of(input logic [7:0] s);
    return (s == 8'd0) ? 25'h080000 : 25'h0A8000;
  endfunction

  function automatic logic [37:0] dut_out();
    return {bus.loader_active, bus.loader_we, bus.loader_addr, bus.loader_data,
            bus.reset_req, bus.overflow, bus.bad_index};
  endfunction

  function automatic logic [37:0] model_out();
    return {(m_phase == 1 || m_phase == 2), m_we, m_addr, m_data,
            (m_phase != 0), m_ovf, m_bad};
  endfunction

  function automatic wr_t get_write(input int k);
    if (k < writes.size()) return writes[k];
    return '0;
  endfunction

  always @(posedge clk) begin
    int  sz;
    wr_t e;
    if (rst) begin
      m_phase = 0; m_left = 0; m_q.delete();
      m_we = 0; m_ovf = 0; m_bad = 0; m_addr = '0; m_data = '0;
      prev_sync = 0;
    end else begin
      sz = m_q.size();
      if (m_phase == 1 && m_slot >= 2) m_bad = 1;
      if (m_phase == 1 && bus.ioctl_wr && m_slot < 2) begin
        if (sz < DEPTH || bus.mem_sync) m_q.push_back({base_of(m_slot) + bus.ioctl_addr, bus.ioctl_dout});
        else m_ovf = 1;
      end
      if (bus.mem_sync) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_we = 1; m_addr = e.addr; m_data = e.data;
        end else begin
          m_we = 0;
        end
      end
      case (m_phase)
        0, 3: begin
          if (bus.ioctl_download) begin
            m_phase = 1; m_slot = bus.ioctl_index; m_ovf = 0; m_bad = 0;
          end else if (m_phase == 3) begin
            if (m_left == 1) m_phase = 0;
            else m_left--;
          end
        end
        1: if (!bus.ioctl_download) m_phase = 2;
        2: if (bus.mem_sync && sz == 0) begin m_phase = 3; m_left = HOLD; end
        default: m_phase = 0;
      endcase
      prev_sync = bus.mem_sync;
    end
    #1;
    if (prev_sync && bus.loader_we) writes.push_back({bus.loader_addr, bus.loader_data});
    check("cycle_outputs", 64'(dut_out()), 64'(model_out()));
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int period);
    for (int c = 0; c < n; c++) begin
      bus.mem_sync = (period > 0) && (c % period == period - 1);
      tick();
    end
    bus.mem_sync = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] off;
    logic [7:0]  data;
    int          n_wr;
    logic [24:0] exp_addr;
    logic        bad;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cnt;
    int c;
    wr_t w;

    tbl[0] = '{8'd0, 25'h0000000, 8'h11, 1, 25'h0080000, 1'b0};
    tbl[1] = '{8'd1, 25'h0000010, 8'h5A, 1, 25'h00A8010, 1'b0};
    tbl[2] = '{8'd1, 25'h1FFFFFF, 8'h77, 1, 25'h00A7FFF, 1'b0};
    tbl[3] = '{8'd0, 25'h1F80000, 8'h33, 1, 25'h0000000, 1'b0};
    tbl[4] = '{8'd3, 25'h0000005, 8'h99, 0, 25'h0000000, 1'b1};
    tbl[5] = '{8'd2, 25'h0000000, 8'h44, 0, 25'h0000000, 1'b1};

    bus.ioctl_download = 0; bus.ioctl_index = '0; bus.ioctl_wr = 0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0; bus.mem_sync = 0;
    rst = 1;
    tick(); tick();
    check("reset_state", 64'(dut_out()), 64'd0);
    rst = 0;
    tick();

    // single-byte downloads; later ones restart from HOLD
    foreach (tbl[i]) begin
      writes.delete();
      bus.ioctl_download = 1; bus.ioctl_index = tbl[i].idx;
      tick();
      bus.ioctl_wr = 1; bus.ioctl_addr = tbl[i].off; bus.ioctl_dout = tbl[i].data;
      tick();
      bus.ioctl_wr = 0; bus.ioctl_download = 0;
      run(40, 8);
      w = get_write(0);
      check("tbl_nwr", 64'(writes.size()), 64'(tbl[i].n_wr));
      check("tbl_addr", 64'(w.addr), 64'(tbl[i].exp_addr));
      check("tbl_data", 64'(w.data), (tbl[i].n_wr > 0) ? 64'(tbl[i].data) : 64'd0);
      check("tbl_bad", 64'(bus.bad_index), 64'(tbl[i].bad));
    end

    // two bytes, written in order
    writes.delete();
    bus.ioctl_download = 1; bus.ioctl_index = 8'd0;
    tick();
    bus.ioctl_wr = 1; bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'h11; tick();
    bus.ioctl_addr = 25'd1; bus.ioctl_dout = 8'h22; tick();
    bus.ioctl_wr = 0; bus.ioctl_download = 0;
    run(40, 8);
    check("order_n", 64'(writes.size()), 64'd2);
    check("order_0", 64'(get_write(0)), 64'({25'h080000, 8'h11}));
    check("order_1", 64'(get_write(1)), 64'({25'h080001, 8'h22}));

    // six strobes back to back with no slot: four kept, overflow flagged
    writes.delete();
    bus.ioctl_download = 1; bus.ioctl_index = 8'd0;
    tick();
    for (int k = 0; k < 6; k++) begin
      bus.ioctl_wr = 1; bus.ioctl_addr = 25'(k); bus.ioctl_dout = 8'hA0 + 8'(k);
      tick();
    end
    bus.ioctl_wr = 0;
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    bus.ioctl_download = 0;
    run(60, 8);
    check("ovf_nwr", 64'(writes.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      check("ovf_entry", 64'(get_write(k)), 64'({25'h080000 + 25'(k), 8'hA0 + 8'(k)}));

    // reset stretch after an empty download
    bus.ioctl_download = 1; bus.ioctl_index = 8'd1;
    tick();
    bus.ioctl_download = 0;
    c = 0;
    while (bus.loader_active && c < 100) begin
      bus.mem_sync = (c % 8 == 7); tick(); c++;
    end
    bus.mem_sync = 0;
    check("drain_exit", 64'(bus.loader_active), 64'd0);
    cnt = 0;
    while (bus.reset_req && cnt < 5000) begin
      bus.mem_sync = ((c + cnt) % 8 == 7); tick(); cnt++;
    end
    bus.mem_sync = 0;
    check("hold_len", 64'(cnt), 64'(HOLD));

    // asynchronous reset with three bytes buffered
    writes.delete();
    bus.ioctl_download = 1; bus.ioctl_index = 8'd1;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.ioctl_wr = 1; bus.ioctl_addr = 25'(k); bus.ioctl_dout = 8'hC0 + 8'(k);
      tick();
    end
    bus.ioctl_wr = 0;
    #3 rst = 1;
    #1 check("async_reset", 64'(dut_out()), 64'd0);
    tick(); tick();
    rst = 0; bus.ioctl_download = 0;
    run(40, 8);
    check("no_stale", 64'(writes.size()), 64'd0);
    check("idle_after", 64'({bus.loader_active, bus.reset_req}), 64'd0);

    // random traffic, model checks every cycle
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 24) == 0) bus.ioctl_download = ~bus.ioctl_download;
      bus.ioctl_index = ($urandom_range(0, 9) == 0) ? 8'(2 + $urandom_range(0, 5)) : 8'($urandom_range(0, 1));
      bus.ioctl_wr    = ($urandom_range(0, 1) == 1);
      bus.ioctl_addr  = 25'($urandom());
      bus.ioctl_dout  = 8'($urandom());
      bus.mem_sync    = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.ioctl_wr = 0; bus.ioctl_download = 0; bus.mem_sync = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
